// File: rtl/board_settle_spawner.sv
// Post-move controller for the 4x4 merge grid: waits for the board to settle, spawns a tile
// into a pseudo-random empty cell, counts merges and flags win / game-over.
module board_settle_spawner #(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1,
   parameter logic [3:0]  WIN_VALUE     = 4'd11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        init_start,
   input  logic        move_start,
   input  logic [63:0] board_value,
   input  logic [15:0] node_score,
   input  logic [31:0] node_movable,
   output logic [15:0] preset_ext,
   output logic [3:0]  value_preset,
   output logic        busy,
   output logic        spawned,
   output logic [15:0] merge_count,
   output logic        win,
   output logic        game_over
);

   typedef enum logic [2:0] {IDLE, SETTLE, PICK, WRITE, GAP, CHECK} state_t;

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

   state_t      state, state_nxt;
   logic [15:0] lfsr;
   logic [63:0] board_prev;
   logic [63:0] snapshot;
   logic [7:0]  settle_cnt;
   logic [3:0]  scan_idx;
   logic [4:0]  scan_n;
   logic [1:0]  spawns_left;
   logic        changed_now;
   logic        board_full;
   logic        any_win;
   logic [3:0]  cell_at_scan;

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
   endfunction

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] n;
      n = '0;
      for (int i = 0; i < 16; i++) n = n + {4'd0, v[i]};
      return n;
   endfunction

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [4:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {12'd0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   assign changed_now  = (board_value != board_prev);
   assign cell_at_scan = board_value[{scan_idx, 2'b00} +: 4];
   assign busy         = (state != IDLE);

   always_comb begin
      board_full = 1'b1;
      any_win    = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (board_value[4*i +: 4] == 4'd0)      board_full = 1'b0;
         if (board_value[4*i +: 4] == WIN_VALUE) any_win    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (init_start)                   state_nxt = PICK;
            else if (move_start && !game_over) state_nxt = SETTLE;
         end
         SETTLE: begin
            if (!changed_now && settle_cnt == SETTLE_LAST)
               state_nxt = (board_value != snapshot) ? PICK : CHECK;
         end
         PICK: begin
            if (cell_at_scan == 4'd0) state_nxt = WRITE;
            else if (scan_n == 5'd15)  state_nxt = CHECK;
         end
         WRITE:   state_nxt = GAP;
         GAP:     state_nxt = (spawns_left != 2'd0) ? PICK : CHECK;
         CHECK:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Control and registered outputs; spawn strobes are launched on the PICK->WRITE edge
   // so they are visible exactly during the WRITE cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr         <= LFSR_SEED;
         spawns_left  <= 2'd0;
         preset_ext   <= '0;
         value_preset <= '0;
         spawned      <= 1'b0;
         merge_count  <= '0;
         win          <= 1'b0;
         game_over    <= 1'b0;
      end else begin
         lfsr         <= lfsr_next(lfsr);
         merge_count  <= sat_add16(merge_count, popcount16(node_score));
         if (any_win) win <= 1'b1;
         preset_ext   <= '0;
         value_preset <= '0;
         spawned      <= 1'b0;
         case (state)
            IDLE: begin
               if (init_start) begin
                  spawns_left <= 2'd2;
                  game_over   <= 1'b0;
               end
            end
            SETTLE: if (state_nxt == PICK) spawns_left <= 2'd1;
            PICK: begin
               if (state_nxt == WRITE) begin
                  preset_ext   <= 16'd1 << scan_idx;
                  value_preset <= (lfsr[7:5] == 3'd0) ? 4'd2 : 4'd1;
                  spawned      <= 1'b1;
               end
            end
            WRITE: spawns_left <= spawns_left - 2'd1;
            CHECK: if (board_full && node_movable == 32'd0) game_over <= 1'b1;
            default: ;
         endcase
      end
   end

   // Datapath registers: only meaningful once the FSM has set them up.
   always_ff @(posedge clk) begin
      board_prev <= board_value;
      if (state == IDLE && move_start) snapshot <= board_value;
      if (state != SETTLE)  settle_cnt <= 8'd0;
      else if (changed_now) settle_cnt <= 8'd0;
      else                  settle_cnt <= settle_cnt + 8'd1;
      if (state != PICK && state_nxt == PICK) begin
         scan_idx <= lfsr[3:0];
         scan_n   <= 5'd0;
      end else if (state == PICK) begin
         scan_idx <= scan_idx + 4'd1;
         scan_n   <= scan_n + 5'd1;
      end
   end

endmodule

// File: tb/tb_board_settle_spawner.sv
// Scoreboard bench for board_settle_spawner: models the grid's preset path and checks
// spawn placement, settle timing, merge saturation and the sticky flags.
module tb_board_settle_spawner;

   logic        clk = 1'b0;
   logic        rst;
   logic        init_start;
   logic        move_start;
   logic [63:0] board_value;
   logic [15:0] node_score;
   logic [31:0] node_movable;
   logic [15:0] preset_ext;
   logic [3:0]  value_preset;
   logic        busy;
   logic        spawned;
   logic [15:0] merge_count;
   logic        win;
   logic        game_over;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int busy_cycles = 0;
   bit model_en = 1'b0;
   logic [15:0] preset_seen;

   logic [15:0] exp_q[$];
   logic [15:0] obs_pre_q[$];
   logic [3:0]  obs_val_q[$];
   bit          obs_empty_q[$];
   int          obs_cyc_q[$];

   always #5 clk = ~clk;

   board_settle_spawner #(
      .SETTLE_CYCLES(4),
      .LFSR_SEED(16'hACE1),
      .WIN_VALUE(4'd11)
   ) dut (
      .clk(clk),
      .rst(rst),
      .init_start(init_start),
      .move_start(move_start),
      .board_value(board_value),
      .node_score(node_score),
      .node_movable(node_movable),
      .preset_ext(preset_ext),
      .value_preset(value_preset),
      .busy(busy),
      .spawned(spawned),
      .merge_count(merge_count),
      .win(win),
      .game_over(game_over)
   );

   // One cycle: sample outputs at the falling edge and emulate the nodes' preset path.
   task automatic tick();
      int idx;
      @(negedge clk);
      cyc++;
      if (busy) busy_cycles++;
      preset_seen = preset_seen | preset_ext;
      if (spawned) begin
         idx = 0;
         for (int i = 0; i < 16; i++) if (preset_ext[i]) idx = i;
         obs_pre_q.push_back(preset_ext);
         obs_val_q.push_back(value_preset);
         obs_empty_q.push_back(board_value[4*idx +: 4] == 4'd0);
         obs_cyc_q.push_back(cyc);
         if (model_en) board_value[4*idx +: 4] = value_preset;
      end
   endtask

   task automatic clear_obs();
      exp_q.delete();
      obs_pre_q.delete();
      obs_val_q.delete();
      obs_empty_q.delete();
      obs_cyc_q.delete();
      preset_seen = '0;
      busy_cycles = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1; init_start = 1'b1; move_start = 1'b1;
      board_value = '0; node_score = '0; node_movable = '0;
      tick(); tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (preset_ext !== 16'h0) begin errors++; $display("FAIL reset_preset: got %h want 0000", preset_ext); end
      checks++; if (spawned !== 1'b0 || value_preset !== 4'd0) begin errors++; $display("FAIL reset_spawn: spawned %b value %0d want 0 0", spawned, value_preset); end
      checks++; if (merge_count !== 16'h0 || win !== 1'b0 || game_over !== 1'b0) begin errors++; $display("FAIL reset_flags: merge %h win %b go %b want 0", merge_count, win, game_over); end
      checks++; if (dut.lfsr !== 16'hACE1) begin errors++; $display("FAIL reset_lfsr: got %h want ace1", dut.lfsr); end
      rst = 1'b0; init_start = 1'b0; move_start = 1'b0;
      tick();
      checks++; if (dut.lfsr !== 16'hE270) begin errors++; $display("FAIL lfsr_step: got %h want e270", dut.lfsr); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy %b want 0", busy); end
   endtask

   task automatic test_init();
      int n;
      logic [15:0] e, p, first_p;
      logic [3:0] v;
      bit em;
      int oc;
      clear_obs();
      model_en = 1'b1;
      board_value = '0;
      tick();
      exp_q.push_back(16'h0);
      exp_q.push_back(16'h0);
      init_start = 1'b1;
      tick();
      init_start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL init_busy: got %b want 1", busy); end
      checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL init_clears_go: got %b want 0", game_over); end
      n = 0;
      while (busy && n < 80) begin tick(); n++; end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL init_timeout: busy %b want 0", busy); end
      checks++; if (obs_pre_q.size() != exp_q.size()) begin errors++; $display("FAIL init_spawn_count: got %0d want %0d", obs_pre_q.size(), exp_q.size()); end
      first_p = '0;
      while (exp_q.size() > 0 && obs_pre_q.size() > 0) begin
         e = exp_q.pop_front(); p = obs_pre_q.pop_front(); v = obs_val_q.pop_front();
         em = obs_empty_q.pop_front(); oc = obs_cyc_q.pop_front();
         checks++; if (!$onehot(p)) begin errors++; $display("FAIL init_onehot: got %h at cycle %0d want one-hot", p, oc); end
         checks++; if (v != 4'd1 && v != 4'd2) begin errors++; $display("FAIL init_value: got %0d want 1 or 2", v); end
         checks++; if (!em) begin errors++; $display("FAIL init_target_empty: preset %h hit occupied cell, want empty", p); end
         if (e != 16'h0) begin
            checks++; if (p !== e) begin errors++; $display("FAIL init_target: got %h want %h", p, e); end
         end
         if (first_p == 16'h0) first_p = p;
         else begin
            checks++; if (p == first_p) begin errors++; $display("FAIL init_distinct: got %h twice want distinct", p); end
         end
      end
      checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL init_no_go: got %b want 0", game_over); end
   endtask

   task automatic test_no_change();
      int n;
      model_en = 1'b1;
      board_value = 64'h0000_0300_0020_0001;
      node_movable = 32'h0000_0001;
      tick(); tick();
      clear_obs();
      move_start = 1'b1;
      tick();
      move_start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nochg_busy: got %b want 1", busy); end
      n = 0;
      while (busy && n < 40) begin tick(); n++; end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nochg_timeout: busy %b want 0", busy); end
      checks++; if (obs_pre_q.size() != 0) begin errors++; $display("FAIL nochg_spawns: got %0d want 0", obs_pre_q.size()); end
      checks++; if (preset_seen !== 16'h0) begin errors++; $display("FAIL nochg_preset: got %h want 0000", preset_seen); end
      checks++; if (busy_cycles != 5) begin errors++; $display("FAIL nochg_duration: got %0d want 5", busy_cycles); end
   endtask

   task automatic test_toggle();
      int n, last_chg;
      logic [15:0] e, p;
      logic [3:0] v;
      bit em;
      int oc;
      model_en = 1'b1;
      node_movable = 32'h0000_0001;
      board_value = 64'h0000_0000_0000_0001;
      tick(); tick();
      clear_obs();
      exp_q.push_back(16'h0200);
      move_start = 1'b1;
      tick();
      move_start = 1'b0;
      board_value = 64'h0000_0000_0000_0031;
      tick();
      board_value = 64'h0000_0000_0000_0032;
      tick();
      board_value = 64'h1212_1201_2121_2121;
      last_chg = cyc;
      n = 0;
      while (busy && n < 60) begin tick(); n++; end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL toggle_timeout: busy %b want 0", busy); end
      checks++; if (obs_pre_q.size() != exp_q.size()) begin errors++; $display("FAIL toggle_spawn_count: got %0d want %0d", obs_pre_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_pre_q.size() > 0) begin
         e = exp_q.pop_front(); p = obs_pre_q.pop_front(); v = obs_val_q.pop_front();
         em = obs_empty_q.pop_front(); oc = obs_cyc_q.pop_front();
         checks++; if (p !== e) begin errors++; $display("FAIL toggle_target: got %h want %h", p, e); end
         checks++; if (v != 4'd1 && v != 4'd2) begin errors++; $display("FAIL toggle_value: got %0d want 1 or 2", v); end
         checks++; if (oc < last_chg + 6 || oc > last_chg + 21) begin errors++; $display("FAIL toggle_timing: spawn at +%0d want +6..+21 after last change", oc - last_chg); end
      end
      checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL toggle_no_go: got %b want 0", game_over); end
   endtask

   task automatic test_full_board();
      int n;
      model_en = 1'b1;
      node_movable = 32'h0;
      board_value = 64'h2121_2121_2121_2121;
      tick(); tick();
      clear_obs();
      move_start = 1'b1;
      tick();
      move_start = 1'b0;
      board_value = 64'h1212_1212_1212_1212;
      busy_cycles = 0;
      tick();
      n = 0;
      while (busy && n < 60) begin tick(); n++; end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_timeout: busy %b want 0", busy); end
      checks++; if (obs_pre_q.size() != 0 || preset_seen !== 16'h0) begin errors++; $display("FAIL full_no_spawn: spawns %0d preset %h want 0", obs_pre_q.size(), preset_seen); end
      checks++; if (busy_cycles != 21) begin errors++; $display("FAIL full_pick_duration: busy %0d cycles after change want 21", busy_cycles); end
      checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL full_game_over: got %b want 1", game_over); end
      move_start = 1'b1;
      tick();
      move_start = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL go_ignores_move: busy %b want 0", busy); end
      tick(); tick();
      checks++; if (busy !== 1'b0 || game_over !== 1'b1) begin errors++; $display("FAIL go_sticky: busy %b go %b want 0 1", busy, game_over); end
   endtask

   task automatic test_merge_sat();
      node_score = 16'h8001;
      tick();
      node_score = 16'h0;
      checks++; if (merge_count !== 16'd2) begin errors++; $display("FAIL merge_basic: got %h want 0002", merge_count); end
      node_score = 16'hFFFF;
      for (int i = 0; i < 4095; i++) tick();
      node_score = 16'h0FFF;
      tick();
      node_score = 16'h0;
      checks++; if (merge_count !== 16'hFFFE) begin errors++; $display("FAIL merge_fffe: got %h want fffe", merge_count); end
      node_score = 16'h0003;
      tick();
      node_score = 16'h0;
      checks++; if (merge_count !== 16'hFFFF) begin errors++; $display("FAIL merge_saturate: got %h want ffff", merge_count); end
      node_score = 16'h0001;
      tick();
      node_score = 16'h0;
      checks++; if (merge_count !== 16'hFFFF) begin errors++; $display("FAIL merge_hold: got %h want ffff", merge_count); end
   endtask

   task automatic test_win();
      model_en = 1'b0;
      board_value = 64'h0000_0000_00A0_0000;
      tick(); tick();
      checks++; if (win !== 1'b0) begin errors++; $display("FAIL win_below: got %b want 0", win); end
      board_value = 64'h0000_0000_00B0_0000;
      tick();
      board_value = 64'h0000_0000_0010_0000;
      tick();
      checks++; if (win !== 1'b1) begin errors++; $display("FAIL win_set: got %b want 1", win); end
      tick(); tick(); tick();
      checks++; if (win !== 1'b1) begin errors++; $display("FAIL win_sticky: got %b want 1", win); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (win !== 1'b0 || merge_count !== 16'h0 || game_over !== 1'b0) begin errors++; $display("FAIL win_reset: win %b merge %h go %b want 0", win, merge_count, game_over); end
   endtask

   initial begin
      test_reset();
      test_init();
      test_no_change();
      test_toggle();
      test_full_board();
      test_init();
      test_merge_sat();
      test_win();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/board_settle_spawner.md
Name: board_settle_spawner

Overview:
- Sits downstream of the 4x4 grid of merge/shift nodes.
- Watches the flattened board after each move and detects when the dataflow has settled.
- If the move changed the board, it places a new tile into a pseudo-random empty cell through the nodes' preset path.
- It also accumulates merge events and flags win and game-over.

Parameters:
- SETTLE_CYCLES, 4: consecutive unchanged cycles required to declare the board settled.
- LFSR_SEED, 16'hACE1: reset value of the spawn LFSR; must be nonzero.
- WIN_VALUE, 4'd11: cell code that signals a win (2^11 = 2048).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- init_start  in  1  one-cycle pulse: spawn two tiles onto a freshly cleared board
- move_start  in  1  one-cycle pulse: a move has been launched into the grid
- board_value  in  64  cell i occupies [4i+3:4i]; cell 0 is top-left, row-major; 0 means empty
- node_score  in  16  bit i is the score pulse from cell i (a merge happened)
- node_movable  in  32  bits [2i+1:2i] are the movable flags of cell i ({vertical, horizontal})
- preset_ext  out  16  one-hot preset strobe to cell i
- value_preset  out  4  tile code written with preset_ext
- busy  out  1  high whenever the FSM is not in IDLE
- spawned  out  1  one-cycle pulse when a tile is written
- merge_count  out  16  running count of merge pulses; saturates at 16'hFFFF
- win  out  1  sticky; set when any cell equals WIN_VALUE
- game_over  out  1  sticky; set on a failed CHECK

Behaviour:
- Reset (rst=1 at a clk edge) forces the following, regardless of the current state; a reset in the middle of a spawn drops that spawn:
  - state IDLE
  - preset_ext = 0, value_preset = 0, spawned = 0, busy = 0
  - merge_count = 0, win = 0, game_over = 0
  - LFSR = LFSR_SEED, spawns_left = 0
- LFSR:
  - 16-bit Galois, taps mask 16'hB400, shifts right.
  - Advances every cycle outside reset.
- Board snapshot:
  - board_prev is a register loaded with board_value every cycle.
  - changed_now = (board_value != board_prev).
- Merge counting:
  - Each cycle, merge_count += popcount(node_score), saturating at 16'hFFFF.
  - Counting is independent of the FSM state.
- win:
  - Set in any cycle where any cell equals WIN_VALUE.
  - Cleared only by rst.
- States:
  - IDLE:
    - On init_start: spawns_left = 2, go to PICK. init_start has priority over move_start.
    - On move_start: snapshot = board_value, settle_cnt = 0, go to SETTLE.
    - game_over=1: move_start is ignored and the FSM stays in IDLE. init_start is still accepted and clears game_over.
  - SETTLE:
    - settle_cnt resets to 0 on changed_now; otherwise it increments.
    - When settle_cnt == SETTLE_CYCLES-1 with changed_now=0: go to PICK with spawns_left = 1 if board_value != snapshot, else go to CHECK (no spawn).
  - PICK:
    - On entry, latch scan_idx = lfsr[3:0] and scan_n = 0.
    - Each cycle, examine one cell at scan_idx:
      - If it is empty, latch target = scan_idx and go to WRITE.
      - Otherwise scan_idx = scan_idx+1 (mod 16, wraps 15 -> 0) and scan_n++.
    - If scan_n reaches 16 with no empty cell, go to CHECK without spawning.
    - Worst-case time in PICK is 16 cycles.
  - WRITE:
    - For exactly one cycle: preset_ext = 1<<target, value_preset = (lfsr[7:5]==0) ? 2 : 1, spawned = 1.
    - spawns_left--.
    - Next state: GAP.
  - GAP:
    - One cycle so the node latches the preset and board_value reflects it.
    - If spawns_left != 0, go to PICK; else go to CHECK.
  - CHECK:
    - One cycle.
    - game_over is set if all 16 cells are nonzero AND node_movable == 0.
    - Next state: IDLE.
- Outputs are registered.
- preset_ext is all-zero in every state except WRITE.
- move_start or init_start arriving while busy=1 is ignored; no queuing.
- Latency from move_start to spawned (stable board, first scanned cell empty) is SETTLE_CYCLES+2 cycles.

Test Plan:
- Reset with init_start high in the same cycle -> outputs zero, FSM stays IDLE, and LFSR holds LFSR_SEED the next cycle.
- init_start on an all-zero board -> exactly two spawned pulses, each with one-hot preset_ext, value_preset in {1,2}, and distinct targets once the bench model reflects the first write; busy deasserts after CHECK.
- move_start with board unchanged for SETTLE_CYCLES -> no spawned pulse, preset_ext stays 0, busy returns low.
- move_start, then board toggles for 3 cycles and ends different from the snapshot with only cell 9 empty -> exactly one spawn with preset_ext = 16'h0200, issued only after SETTLE_CYCLES stable cycles.
- Full board after a change, no empty cells, node_movable=0 -> PICK times out after 16 cycles, no spawn, game_over=1; a later move_start is ignored.
- node_score = 16'h0003 for one cycle with merge_count = 16'hFFFE -> merge_count = 16'hFFFF (saturation). Separately, a cell equal to 11 -> win=1 and held until rst.
